interfaz_alu_uart: RTL

INTERFAZ_ALU_UART -- requirements
Module: interfaz_alu_uart

---
 rtl/interfaz_alu_uart.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/interfaz_alu_uart.sv
// interfaz_alu_uart: frames three received UART bytes (operand A, operand B,
// opcode) for a combinational ALU and sends the ALU result back through the
// UART transmitter.
// Optional feature: define INTERFAZ_ALU_TIMEOUT_EN to enable an inter-byte
// timeout that discards a partial frame after TIMEOUT_CICLOS idle cycles.
//
// Handshake: rx_listo is a one-cycle strobe qualifying rx_dato in the same
// cycle (there is no back-pressure, so bytes arriving while a result is being
// computed or sent are dropped); tx_inicio is a one-cycle start strobe that is
// only raised on a cycle where tx_ocupado was sampled low.
module interfaz_alu_uart #(
    parameter int NBITS          = 8,
    parameter int COD_OP         = 6,
    parameter int TIMEOUT_CICLOS = 50000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NBITS-1:0]  rx_dato,
    input  logic              rx_listo,
    input  logic [NBITS-1:0]  resultado,
    input  logic              tx_ocupado,
    output logic [NBITS-1:0]  operando_A,
    output logic [NBITS-1:0]  operando_B,
    output logic [COD_OP-1:0] cod_operacion,
    output logic [NBITS-1:0]  tx_dato,
    output logic              tx_inicio,
    output logic              operandos_validos,
    output logic              error_timeout,
    output logic [2:0]        estado_dbg
);

    typedef enum logic [2:0] {
        ESPERA_A  = 3'd0,
        ESPERA_B  = 3'd1,
        ESPERA_OP = 3'd2,
        CALCULO   = 3'd3,
        ENVIAR    = 3'd4
    } estado_t;

    estado_t estado;
    estado_t estado_sig;

    logic cargar_a;
    logic cargar_b;
    logic cargar_op;
    logic cargar_tx;
    logic fijar_validos;
    logic vencido;

    // Current state is exported for observation only.
    assign estado_dbg = estado;

`ifdef INTERFAZ_ALU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;

    logic [CW-1:0] contador;
    logic          esperando;

    assign esperando = (estado == ESPERA_B) || (estado == ESPERA_OP);
    // A received byte in the same cycle always beats the timeout.
    assign vencido   = esperando && !rx_listo && (contador == CW'(TIMEOUT_CICLOS - 1));

    // Idle-cycle counter: runs only while a partial frame is waiting for bytes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            contador <= '0;
        end else if (rx_listo || vencido || !esperando) begin
            contador <= '0;
        end else begin
            contador <= contador + 1'b1;
        end
    end

    // One-cycle pulse marking the discarded partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_timeout <= 1'b0;
        end else begin
            error_timeout <= vencido;
        end
    end
`else
    assign vencido       = 1'b0;
    assign error_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= ESPERA_A;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic and one-cycle load strobes for the datapath.
    always_comb begin
        estado_sig    = estado;
        cargar_a      = 1'b0;
        cargar_b      = 1'b0;
        cargar_op     = 1'b0;
        cargar_tx     = 1'b0;
        fijar_validos = 1'b0;
        case (estado)
            ESPERA_A: begin
                if (rx_listo) begin
                    cargar_a   = 1'b1;
                    estado_sig = ESPERA_B;
                end
            end
            ESPERA_B: begin
                if (rx_listo) begin
                    cargar_b   = 1'b1;
                    estado_sig = ESPERA_OP;
                end else if (vencido) begin
                    estado_sig = ESPERA_A;
                end
            end
            ESPERA_OP: begin
                if (rx_listo) begin
                    cargar_op  = 1'b1;
                    estado_sig = CALCULO;
                end else if (vencido) begin
                    estado_sig = ESPERA_A;
                end
            end
            CALCULO: begin
                // One cycle for the ALU to settle on the new operands.
                fijar_validos = 1'b1;
                estado_sig    = ENVIAR;
            end
            ENVIAR: begin
                if (!tx_ocupado) begin
                    cargar_tx  = 1'b1;
                    estado_sig = ESPERA_A;
                end
            end
            default: begin
                estado_sig = ESPERA_A;
            end
        endcase
    end

    // Operand, opcode and transmit registers; each changes only on its strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operando_A        <= '0;
            operando_B        <= '0;
            cod_operacion     <= '0;
            tx_dato           <= '0;
            tx_inicio         <= 1'b0;
            operandos_validos <= 1'b0;
        end else begin
            tx_inicio <= cargar_tx;
            if (cargar_a) begin
                operando_A        <= rx_dato;
                operandos_validos <= 1'b0;
            end
            if (cargar_b) begin
                operando_B <= rx_dato;
            end
            if (cargar_op) begin
                cod_operacion <= rx_dato[COD_OP-1:0];
            end
            if (fijar_validos) begin
                operandos_validos <= 1'b1;
            end
            if (cargar_tx) begin
                tx_dato <= resultado;
            end
        end
    end

endmodule
